multiplier_factor_checker: RTL and testbench

// - Forward-direction checker for the multiplier_factorize SAT benchmarks.
// - Accepts a candidate assignment (a, b) from the CSAT solver's result port and recomputes a*b with a serial

---
 rtl/multiplier_factor_checker_pkg.sv | 18 +
 rtl/multiplier_factor_checker_serial_mul_core.sv | 58 +++++
 rtl/multiplier_factor_checker.sv | 91 +++++++++
 tb/tb_multiplier_factor_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_factor_checker_pkg.sv
// Shared types and width helpers for the multiplier_factorize result checker.
package mult_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic int cnt_w(input int b_w);
        return $clog2(b_w + 1);
    endfunction

endpackage

// File: rtl/multiplier_factor_checker_serial_mul_core.sv
// Serial shift-add multiplier: one multiplier bit per cycle, exactly B_W iterations per start.
module serial_mul_core
    import mult_check_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [A_W-1:0]              a,
    input  logic [B_W-1:0]              b,
    output logic                        done,
    output logic [prod_w(A_W, B_W)-1:0] product
);

    localparam int PROD_W = prod_w(A_W, B_W);
    localparam int CNT_W  = cnt_w(B_W);

    logic [PROD_W-1:0] mcand;
    logic [B_W-1:0]    mplier;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              busy;

    // High during the final iteration; no early exit when mplier runs out of ones.
    assign done    = busy && (cnt == CNT_W'(B_W - 1));
    assign product = acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others (mcand/acc ordering depends on it).
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= PROD_W'(a);
            mplier <= b;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multiplier_factor_checker.sv
// Forward checker for multiplier_factorize: recomputes a*b serially and compares against TARGET.
// Optional macro MULT_CHECK_NONTRIVIAL_EN additionally rejects factorisations with a<2 or b<2.
module multiplier_factor_checker
    import mult_check_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 5,
    parameter int TARGET = 509
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [A_W-1:0]              in_a,
    input  logic [B_W-1:0]              in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sat,
    output logic [prod_w(A_W, B_W)-1:0] out_product
);

    localparam int PROD_W = prod_w(A_W, B_W);

    state_t            state;
    state_t            state_next;
    logic              start;
    logic              mul_done;
    logic [PROD_W-1:0] product;
    logic              hit;
    logic              nontrivial;

    assign in_ready = (state == IDLE);
    assign start    = in_valid && in_ready;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            MUL:     if (mul_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    serial_mul_core #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (product)
    );

    assign hit = (product == PROD_W'(TARGET));

`ifdef MULT_CHECK_NONTRIVIAL_EN
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;

    // Operand copies are pure datapath, only read in DONE after a fresh capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    assign nontrivial = (a_q >= A_W'(2)) && (b_q >= B_W'(2));
`else
    assign nontrivial = 1'b1;
`endif

    // Verdict is a function of registered state only, so it holds steady while out_ready is low.
    assign out_valid   = (state == DONE);
    assign out_sat     = out_valid && hit && nontrivial;
    assign out_product = product;

endmodule

// File: tb/tb_multiplier_factor_checker.sv
// Directed, table-driven bench for multiplier_factor_checker (TARGET=143 instance).
module tb_multiplier_factor_checker;

    localparam int A_W     = 8;
    localparam int B_W     = 5;
    localparam int TARGET  = 143;
    localparam int PROD_W  = A_W + B_W;
    localparam int LATENCY = B_W + 1;

`ifdef MULT_CHECK_NONTRIVIAL_EN
    localparam logic TRIVIAL_SAT = 1'b0;
`else
    localparam logic TRIVIAL_SAT = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [A_W-1:0]    in_a;
    logic [B_W-1:0]    in_b;
    logic              out_valid;
    logic              out_ready;
    logic              out_sat;
    logic [PROD_W-1:0] out_product;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multiplier_factor_checker #(
        .A_W    (A_W),
        .B_W    (B_W),
        .TARGET (TARGET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sat     (out_sat),
        .out_product (out_product)
    );

    typedef struct {
        logic [A_W-1:0]    a;
        logic [B_W-1:0]    b;
        logic [PROD_W-1:0] product;
        logic              sat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake one candidate in, wait for the verdict (bounded), check it, then accept it.
    task automatic run_txn(input string tag, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                           input logic [PROD_W-1:0] exp_product, input logic exp_sat);
        int cyc;
        check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        cyc      = 1;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(LATENCY));
        check({tag, " product"}, 32'(out_product), 32'(exp_product));
        check({tag, " sat"}, 32'(out_sat), 32'(exp_sat));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid dropped"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [PROD_W-1:0] held_product;
        logic              held_sat;
        int                seen;

        vecs[0] = '{a: 8'd255, b: 5'd2,  product: 13'd510,  sat: 1'b0};
        vecs[1] = '{a: 8'd11,  b: 5'd13, product: 13'd143,  sat: 1'b1};
        vecs[2] = '{a: 8'd13,  b: 5'd11, product: 13'd143,  sat: 1'b1};
        vecs[3] = '{a: 8'd143, b: 5'd1,  product: 13'd143,  sat: TRIVIAL_SAT};
        vecs[4] = '{a: 8'd0,   b: 5'd31, product: 13'd0,    sat: 1'b0};
        vecs[5] = '{a: 8'd200, b: 5'd0,  product: 13'd0,    sat: 1'b0};
        vecs[6] = '{a: 8'd255, b: 5'd31, product: 13'd7905, sat: 1'b0};
        vecs[7] = '{a: 8'd71,  b: 5'd2,  product: 13'd142,  sat: 1'b0};
        vecs[8] = '{a: 8'd1,   b: 5'd1,  product: 13'd1,    sat: 1'b0};
        vecs[9] = '{a: 8'd170, b: 5'd21, product: 13'd3570, sat: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_sat", 32'(out_sat), 32'd0);
        check("reset out_product", 32'(out_product), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].product, vecs[i].sat);
        end

        // Back-pressure: verdict must hold for 10 cycles while a new candidate is offered and refused.
        in_valid = 1'b1;
        in_a     = 8'd11;
        in_b     = 5'd13;
        step();
        in_a = 8'd3;
        in_b = 5'd5;
        seen = 0;
        while (!out_valid && seen < 50) begin
            step();
            seen++;
        end
        check("stall verdict reached", 32'(out_valid), 32'd1);
        held_product = out_product;
        held_sat     = out_sat;
        check("stall product", 32'(held_product), 32'd143);
        check("stall sat", 32'(held_sat), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall c%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall c%0d product", i), 32'(out_product), 32'(held_product));
            check($sformatf("stall c%0d sat", i), 32'(out_sat), 32'(held_sat));
            check($sformatf("stall c%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall release out_valid", 32'(out_valid), 32'd0);
        check("stall release in_ready", 32'(in_ready), 32'd1);
        step();
        check("refused candidate not started", 32'(in_ready), 32'd1);

        // Abort in the third MUL cycle: no verdict may appear afterwards.
        in_valid = 1'b1;
        in_a     = 8'd11;
        in_b     = 5'd13;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("abort no verdict", 32'(seen), 32'd0);
        run_txn("post-abort", 8'd0, 5'd31, 13'd0, 1'b0);

        // Back-to-back with out_ready tied high: one candidate per B_W+2 cycles.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'd11;
        in_b      = 5'd13;
        seen      = 0;
        for (int i = 0; i < 2 * (B_W + 2); i++) begin
            if (out_valid) seen++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("throughput verdicts", 32'(seen), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
